// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between the bus fabric (master side) and the SRAM slave.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder for DMA bursts: byte-lane writes, programmable wait states
// per beat and the two-cycle ERROR response for out-of-window or misaligned accesses.
module ahb_sram_slave #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          WAIT_CYC  = 0
) (
  input logic             HCLK,
  input logic             HRESET,
  ahb_sram_slave_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  localparam logic [2:0] WAIT_LOAD = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

  logic [31:0]       mem [2**ADDR_W];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              hreadyout_q, hreadyout_d;
  logic [1:0]        hresp_q, hresp_d;
  logic [31:0]       hrdata_q, hrdata_d;
  logic              accept, illegal, commit;
  logic [3:0]        lane_en;
  logic [31:0]       merged;
  logic              unused_bits;

  assign unused_bits = ^{bus.HTRANS[0], bus.HBURST};

  assign accept  = hreadyout_q & bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign illegal = (bus.HADDR[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2])
                 | (bus.HSIZE > 3'd2)
                 | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
                 | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));
  assign commit  = (state_q == S_DATA) & write_q;

  // Word as it will look after the write in DATA commits; also feeds the read bypass.
  always_comb begin
    case (size_q)
      2'd0:    lane_en = 4'b0001 << off_q;
      2'd1:    lane_en = off_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
    merged = mem[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = bus.HWDATA[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = bus.HADDR[ADDR_W+1:2];
          off_d   = bus.HADDR[1:0];
          size_d  = bus.HSIZE[1:0];
          write_d = bus.HWRITE;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (WAIT_CYC > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;
    hrdata_d    = '0;
    if ((state_d == S_DATA) && !write_d) begin
      hrdata_d = (commit && (idx_q == idx_d)) ? merged : mem[idx_d];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      size_q      <= size_d;
      write_q     <= write_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) mem[idx_q] <= merged;
  end

  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (WAIT_CYC 0/2/3) driven by a pipelined
// AHB master task and checked against a byte-addressed reference memory.
module tb_ahb_sram_slave;
  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 1024;

  logic        HCLK = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  int          dut_sel = 0;

  logic        obs_ready;
  logic [1:0]  obs_resp;
  logic [31:0] obs_rdata;

  int test_count = 0;
  int fail_count = 0;

  int          wait_of [3] = '{0, 2, 3};
  logic [31:0] ref_mem [3][DEPTH];

  logic [31:0] x_addr  [64];
  logic        x_write [64];
  logic [2:0]  x_size  [64];
  logic [31:0] x_wdata [64];
  int          n_x = 0;

  logic [31:0] r_rdata      [64];
  logic [1:0]  r_resp_first [64];
  logic [1:0]  r_resp_last  [64];
  int          r_waits      [64];

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus1 ();
  ahb_sram_slave_if bus2 ();

  always #5 HCLK = ~HCLK;

  assign bus0.HSEL = hsel & (dut_sel == 0);
  assign bus1.HSEL = hsel & (dut_sel == 1);
  assign bus2.HSEL = hsel & (dut_sel == 2);
  assign bus0.HADDR = haddr;   assign bus1.HADDR = haddr;   assign bus2.HADDR = haddr;
  assign bus0.HTRANS = htrans; assign bus1.HTRANS = htrans; assign bus2.HTRANS = htrans;
  assign bus0.HWRITE = hwrite; assign bus1.HWRITE = hwrite; assign bus2.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;   assign bus1.HSIZE = hsize;   assign bus2.HSIZE = hsize;
  assign bus0.HBURST = hburst; assign bus1.HBURST = hburst; assign bus2.HBURST = hburst;
  assign bus0.HWDATA = hwdata; assign bus1.HWDATA = hwdata; assign bus2.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;

  assign obs_ready = (dut_sel == 0) ? bus0.HREADYOUT : (dut_sel == 1) ? bus1.HREADYOUT : bus2.HREADYOUT;
  assign obs_resp  = (dut_sel == 0) ? bus0.HRESP     : (dut_sel == 1) ? bus1.HRESP     : bus2.HRESP;
  assign obs_rdata = (dut_sel == 0) ? bus0.HRDATA    : (dut_sel == 1) ? bus1.HRDATA    : bus2.HRDATA;

  ahb_sram_slave #(.ADDR_W(10), .BASE_ADDR(BASE), .WAIT_CYC(0)) u_dut0 (.HCLK(HCLK), .HRESET(hreset), .bus(bus0));
  ahb_sram_slave #(.ADDR_W(10), .BASE_ADDR(BASE), .WAIT_CYC(2)) u_dut1 (.HCLK(HCLK), .HRESET(hreset), .bus(bus1));
  ahb_sram_slave #(.ADDR_W(10), .BASE_ADDR(BASE), .WAIT_CYC(3)) u_dut2 (.HCLK(HCLK), .HRESET(hreset), .bus(bus2));

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_xfer(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
    x_addr[n_x] = a; x_write[n_x] = w; x_size[n_x] = s; x_wdata[n_x] = d;
    n_x++;
  endtask

  task automatic drive_addr(input int i, input logic is_seq);
    hsel   = 1'b1;
    haddr  = x_addr[i];
    htrans = is_seq ? 2'b11 : 2'b10;
    hwrite = x_write[i];
    hsize  = x_size[i];
    hburst = is_seq ? 3'b011 : 3'b000;
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hburst = 3'b000;
  endtask

  // Pipelined master: a new address goes out whenever the slave is ready, while the
  // previous beat's write data is held through its data phase.
  task automatic apply_stimulus(input int n, input logic seq);
    int   nxt, dp, cyc;
    logic first_seen [64];
    logic timed_out;
    nxt = 0; dp = -1; cyc = 0;
    for (int i = 0; i < 64; i++) begin
      r_waits[i] = 0; first_seen[i] = 1'b0;
      r_rdata[i] = 'x; r_resp_first[i] = 'x; r_resp_last[i] = 'x;
    end
    while ((nxt < n || dp >= 0) && cyc < 1000) begin
      @(negedge HCLK);
      cyc++;
      if (dp >= 0) begin
        hwdata = x_wdata[dp];
        if (!first_seen[dp]) begin
          r_resp_first[dp] = obs_resp;
          first_seen[dp]   = 1'b1;
        end
        if (!obs_ready) r_waits[dp]++;
        else begin
          r_rdata[dp]     = obs_rdata;
          r_resp_last[dp] = obs_resp;
        end
      end
      if (obs_ready) begin
        if (nxt < n) begin
          drive_addr(nxt, seq && (nxt > 0));
          dp = nxt;
          nxt++;
        end else begin
          drive_idle();
          dp = -1;
        end
      end
    end
    timed_out = (nxt < n) || (dp >= 0);
    check_output("run_timeout", {31'b0, timed_out}, 32'd0);
  endtask

  // Reference model: byte-addressed window check, alignment by modulo, lane copy per byte.
  task automatic check_results(input int inst, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, word, exp_rd;
      logic [1:0]  exp_resp;
      int          idx, off, nbytes, exp_waits;
      logic        legal;
      a      = x_addr[i];
      nbytes = 1 << x_size[i];
      legal  = (a >= BASE) && (a < BASE + 4 * DEPTH) && (x_size[i] <= 3'd2) && ((a % nbytes) == 0);
      idx    = int'((a - BASE) / 4) % DEPTH;
      off    = int'(a % 4);
      exp_rd = 32'h0;
      if (!legal) begin
        exp_resp  = 2'b01;
        exp_waits = 1;
      end else begin
        exp_resp  = 2'b00;
        exp_waits = wait_of[inst];
        if (x_write[i]) begin
          word = ref_mem[inst][idx];
          for (int b = 0; b < nbytes; b++) word[(off + b) * 8 +: 8] = x_wdata[i][(off + b) * 8 +: 8];
          ref_mem[inst][idx] = word;
        end else begin
          exp_rd = ref_mem[inst][idx];
        end
      end
      check_output($sformatf("inst%0d beat%0d rdata", inst, i), r_rdata[i], exp_rd);
      check_output($sformatf("inst%0d beat%0d resp_first", inst, i), {30'b0, r_resp_first[i]}, {30'b0, exp_resp});
      check_output($sformatf("inst%0d beat%0d resp_last", inst, i), {30'b0, r_resp_last[i]}, {30'b0, exp_resp});
      check_output($sformatf("inst%0d beat%0d waits", inst, i), 32'(r_waits[i]), 32'(exp_waits));
    end
  endtask

  task automatic random_run(input int inst);
    int known_q[$];
    int idx, kind;
    logic [31:0] a;
    dut_sel = inst;
    n_x = 0;
    for (int i = 0; i < 8; i++) begin
      idx = $urandom_range(64, DEPTH - 1);
      add_xfer(BASE + 32'(idx * 4), 1'b1, 3'd2, $urandom);
      known_q.push_back(idx);
    end
    apply_stimulus(n_x, 1'b0);
    check_results(inst, n_x);
    n_x = 0;
    for (int i = 0; i < 40; i++) begin
      idx  = known_q[$urandom_range(0, 7)];
      a    = BASE + 32'(idx * 4);
      kind = $urandom_range(0, 11);
      case (kind)
        0: add_xfer(BASE + 32'h1000 + 32'($urandom_range(0, 4095) * 4), $urandom_range(0, 1) == 1, 3'd2, $urandom);
        1: add_xfer(a + 32'($urandom_range(1, 3)), 1'b1, 3'd2, $urandom);
        2: add_xfer(a + (($urandom_range(0, 1) == 1) ? 32'd1 : 32'd3), 1'b1, 3'd1, $urandom);
        3: add_xfer(a, $urandom_range(0, 1) == 1, 3'($urandom_range(3, 7)), $urandom);
        4, 5, 6: add_xfer(a + 32'($urandom_range(0, 3)), 1'b1, 3'd0, $urandom);
        7, 8: add_xfer(a + 32'($urandom_range(0, 1) * 2), 1'b1, 3'd1, $urandom);
        9: add_xfer(a, 1'b1, 3'd2, $urandom);
        default: add_xfer(a + 32'($urandom_range(0, 3)), 1'b0, 3'd0, 32'h0);
      endcase
    end
    apply_stimulus(n_x, 1'b0);
    check_results(inst, n_x);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", test_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tot;

    // Power-on reset, some idle time, then a second two-cycle reset mid-idle.
    repeat (3) @(negedge HCLK);
    hreset = 1'b0;
    repeat (4) @(negedge HCLK);
    hreset = 1'b1;
    repeat (2) @(negedge HCLK);
    hreset = 1'b0;
    check_output("reset ready0", {31'b0, bus0.HREADYOUT}, 32'd1);
    check_output("reset resp0",  {30'b0, bus0.HRESP}, 32'd0);
    check_output("reset rdata0", bus0.HRDATA, 32'h0);
    check_output("reset ready1", {31'b0, bus1.HREADYOUT}, 32'd1);
    check_output("reset resp1",  {30'b0, bus1.HRESP}, 32'd0);
    check_output("reset rdata1", bus1.HRDATA, 32'h0);
    check_output("reset ready2", {31'b0, bus2.HREADYOUT}, 32'd1);
    check_output("reset resp2",  {30'b0, bus2.HRESP}, 32'd0);
    check_output("reset rdata2", bus2.HRDATA, 32'h0);

    // Zero-wait word write then read back.
    dut_sel = 0; n_x = 0;
    add_xfer(32'h2000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF);
    add_xfer(32'h2000_0010, 1'b0, 3'd2, 32'h0);
    apply_stimulus(n_x, 1'b0);
    check_results(0, n_x);

    // INCR4 write and read with two wait states per beat.
    dut_sel = 1; n_x = 0;
    for (int i = 0; i < 4; i++) add_xfer(32'h2000_0100 + 32'(i * 4), 1'b1, 3'd2, 32'(i + 1));
    apply_stimulus(n_x, 1'b1);
    check_results(1, n_x);
    tot = 0;
    for (int i = 0; i < 4; i++) tot += r_waits[i] + 1;
    check_output("incr4 write cycles", 32'(tot), 32'd12);
    n_x = 0;
    for (int i = 0; i < 4; i++) add_xfer(32'h2000_0100 + 32'(i * 4), 1'b0, 3'd2, 32'h0);
    apply_stimulus(n_x, 1'b1);
    check_results(1, n_x);
    tot = 0;
    for (int i = 0; i < 4; i++) tot += r_waits[i] + 1;
    check_output("incr4 read cycles", 32'(tot), 32'd12);

    // Byte merge into an existing word, then a misaligned halfword that must error.
    dut_sel = 0; n_x = 0;
    add_xfer(32'h2000_0010, 1'b1, 3'd2, 32'h1122_3344);
    add_xfer(32'h2000_0013, 1'b1, 3'd0, 32'hAB00_0000);
    add_xfer(32'h2000_0010, 1'b0, 3'd2, 32'h0);
    add_xfer(32'h2000_0011, 1'b1, 3'd1, 32'hFFFF_FFFF);
    add_xfer(32'h2000_0010, 1'b0, 3'd2, 32'h0);
    apply_stimulus(n_x, 1'b0);
    check_results(0, n_x);
    check_output("byte merge value", r_rdata[2], 32'hAB22_3344);

    // Out-of-window write must error and must not alias onto word 0.
    n_x = 0;
    add_xfer(32'h2000_0000, 1'b1, 3'd2, 32'h0BAD_F00D);
    add_xfer(32'h2000_1000, 1'b1, 3'd2, 32'h1234_5678);
    add_xfer(32'h2000_0000, 1'b0, 3'd2, 32'h0);
    apply_stimulus(n_x, 1'b0);
    check_results(0, n_x);

    // Reset while a write sits in its wait states: the write must be dropped.
    dut_sel = 2; n_x = 0;
    add_xfer(32'h2000_0020, 1'b1, 3'd2, 32'hCAFE_0001);
    apply_stimulus(n_x, 1'b0);
    check_results(2, n_x);
    @(negedge HCLK);
    hsel = 1'b1; haddr = 32'h2000_0020; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(negedge HCLK);
    check_output("wait before reset", {31'b0, obs_ready}, 32'd0);
    hwdata = 32'h5555_AAAA;
    drive_idle();
    hreset = 1'b1;
    @(negedge HCLK);
    hreset = 1'b0;
    check_output("midwait reset ready", {31'b0, obs_ready}, 32'd1);
    check_output("midwait reset resp", {30'b0, obs_resp}, 32'd0);
    repeat (6) @(negedge HCLK);
    check_output("post reset idle ready", {31'b0, obs_ready}, 32'd1);
    n_x = 0;
    add_xfer(32'h2000_0020, 1'b0, 3'd2, 32'h0);
    apply_stimulus(n_x, 1'b0);
    check_results(2, n_x);

    random_run(0);
    random_run(1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end
endmodule
